// File: rtl/interval_scheduler.sv
// interval_scheduler
//   Multi-channel interval toggle controller. One shared prescaler produces a
//   tick every PRESCALE clocks while running; each channel counts ticks up to
//   its own programmable period and toggles its output on every wrap.
//   Period changes made while running are staged in a pending register and
//   take effect at the channel's next wrap, so no interval is ever cut short.
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   start       level-sampled start command (IDLE -> RUN)
//   stop        level-sampled stop command (RUN -> IDLE); wins over start
//   cfg_valid   config write request
//   cfg_ready   config write accept
//   cfg_addr    channel index to write (>= CHANNELS is accepted and ignored)
//   cfg_period  period in ticks; 0 freezes the channel
//   busy        high while in RUN
//   out         toggle level per channel
//   pulse       one-cycle strobe on the edge where out[i] toggles
module interval_scheduler #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int PRESCALE = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [3:0]          cfg_addr,
  input  logic [CNT_W-1:0]    cfg_period,
  output logic                busy,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] pulse
);

  // A one-bit prescaler is kept even for PRESCALE==1 so the vector is never zero-width.
  localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [PRE_W-1:0]    pre_cnt_r;
  logic [CNT_W-1:0]    period_r  [CHANNELS];
  logic [CNT_W-1:0]    pending_r [CHANNELS];
  logic [CNT_W-1:0]    cnt_r     [CHANNELS];
  logic [CHANNELS-1:0] out_r;
  logic [CHANNELS-1:0] pulse_r;
  logic                busy_r;
  logic                cfg_ready_r;

  logic                run_s;
  logic                tick_s;
  logic                adv_s;
  logic                stopping_s;
  logic                wr_en_s;
  logic [CHANNELS-1:0] wr_sel_s;
  logic [CHANNELS-1:0] active_s;
  logic [CHANNELS-1:0] wrap_s;

  assign run_s      = (state_r == RUN);
  assign stopping_s = run_s && stop;
  assign tick_s     = run_s && (pre_cnt_r == PRE_LAST);
  // A tick landing on the stop edge is dropped so stopping never toggles.
  assign adv_s      = tick_s && !stop;
  assign wr_en_s    = cfg_valid && cfg_ready_r;

  assign cfg_ready  = cfg_ready_r;
  assign busy       = busy_r;
  assign out        = out_r;
  assign pulse      = pulse_r;

  // Per-channel write select and wrap detection.
  always_comb begin
    wr_sel_s = {CHANNELS{1'b0}};
    active_s = {CHANNELS{1'b0}};
    wrap_s   = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_en_s && (cfg_addr == 4'(i))) begin
        wr_sel_s[i] = 1'b1;
      end else begin
        wr_sel_s[i] = 1'b0;
      end
      active_s[i] = (period_r[i] != CNT_ZERO);
      wrap_s[i]   = active_s[i] && (cnt_r[i] == (period_r[i] - CNT_ONE));
    end
  end

  // Next-state logic: stop has priority over start, start in RUN is ignored.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start && !stop) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RUN;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register and busy flag, updated on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == RUN);
    end
  end

  // Write-accept flag; writes are never back-pressured outside reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ready_r <= 1'b1;
    end else begin
      cfg_ready_r <= 1'b1;
    end
  end

  // Shared prescaler: counts only while running, cleared on stop and in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_r <= {PRE_W{1'b0}};
    end else if (run_s && !stop) begin
      if (pre_cnt_r == PRE_LAST) begin
        pre_cnt_r <= {PRE_W{1'b0}};
      end else begin
        pre_cnt_r <= pre_cnt_r + PRE_ONE;
      end
    end else begin
      pre_cnt_r <= {PRE_W{1'b0}};
    end
  end

  // Channel counters, toggles and period staging. Later assignments in the
  // loop body override earlier ones: stop clears the counter, and a write
  // to a frozen channel restarts its counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r   <= {CHANNELS{1'b0}};
      pulse_r <= {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
        period_r[i]  <= CNT_ZERO;
        pending_r[i] <= CNT_ZERO;
        cnt_r[i]     <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        pulse_r[i] <= 1'b0;

        if (adv_s && active_s[i]) begin
          if (wrap_s[i]) begin
            cnt_r[i]    <= CNT_ZERO;
            out_r[i]    <= ~out_r[i];
            pulse_r[i]  <= 1'b1;
            // Reads the pending value from before any same-edge write.
            period_r[i] <= pending_r[i];
          end else begin
            cnt_r[i] <= cnt_r[i] + CNT_ONE;
          end
        end else begin
          cnt_r[i] <= cnt_r[i];
        end

        if (stopping_s) begin
          cnt_r[i] <= CNT_ZERO;
        end else begin
          pending_r[i] <= pending_r[i];
        end

        if (wr_sel_s[i]) begin
          if (!run_s) begin
            period_r[i]  <= cfg_period;
            pending_r[i] <= cfg_period;
            cnt_r[i]     <= CNT_ZERO;
          end else if (active_s[i]) begin
            // Running channel: stage only, current interval finishes as is.
            pending_r[i] <= cfg_period;
          end else begin
            // Frozen channel: load now, counting begins on the next tick.
            period_r[i]  <= cfg_period;
            pending_r[i] <= cfg_period;
            cnt_r[i]     <= CNT_ZERO;
          end
        end else begin
          pending_r[i] <= pending_r[i];
        end
      end
    end
  end

endmodule
